mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage data-memory access controller for the MIPS32 datapath. It sits directly upstream of the load-extension stage.
- Takes load/store requests from the pipeline, checks alignment, and generates the word-aligned address, byte enables and replicated write data.
- Runs a req/ack handshake with the data bus and stalls the pipeline until the access completes.
- Latches the raw read word plus byte offset and function code; the extension stage consumes these to sign/zero-extend.

Parameters:
- TIMEOUT, 255: maximum WAIT cycles before the bus is declared dead; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_en  in  1  MEM stage holds a load/store this cycle
- mem_wr  in  1  1 = store, 0 = load
- func_choice  in  3  000 B, 001 BU, 010 H, 011 HU, 100 W; 101-111 reserved
- addr  in  32  effective byte address
- wdata  in  32  store data, right-justified
- flush  in  1  discard the current access
- stall  out  1  freeze the pipeline
- addr_err  out  1  misaligned access or reserved func (combinational)
- bus_err  out  1  one-cycle pulse on timeout
- bus_req  out  1  bus request, registered
- bus_wr  out  1  write strobe
- bus_addr  out  32  {addr[31:2], 2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated write data
- bus_ack  in  1  bus completion, 1 cycle
- bus_rdata  in  32  read word, valid with bus_ack
- load_data  out  32  captured raw word, to the extension stage
- byte_address  out  2  captured addr[1:0]
- load_func  out  3  captured func_choice
- load_valid  out  1  one-cycle pulse: load result ready

Behaviour:
- Reset (async, immediate): state = IDLE; every output register = 0, so bus_req = bus_wr = bus_be = bus_err = load_valid = 0 and bus_addr = bus_wdata = load_data = 0. stall is 0 in IDLE.
- addr_err (combinational, gated by mem_en) is 1 when any of:
  - func is 010/011 and addr[0] = 1
  - func is 100 and addr[1:0] != 00
  - func is 101-111
- When addr_err = 1: no bus request; stall = 0; the pipeline takes the exception.
- Byte enables and write data:
  - Byte: be = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}
  - Half: be = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}
  - Word: be = 1111; wdata passed through
  - bus_be applies to loads too (informational).
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Issue when mem_en & ~addr_err & ~flush: register bus_req = 1, bus_wr, bus_addr, bus_be, bus_wdata; capture byte_address and load_func; clear the timeout counter; go to WAIT.
  - stall = 1 combinationally in the issue cycle.
- WAIT:
  - stall = 1; bus_* held stable until bus_ack.
  - On bus_ack: bus_req = 0; for a load, load_data <= bus_rdata; go to DONE.
  - No ack: counter increments. When counter == TIMEOUT (TIMEOUT != 0): bus_req = 0, load_data <= 0, bus_err pulses on the DONE cycle, go to DONE.
  - bus_ack in the same cycle as the timeout: ack wins, no bus_err.
- DONE:
  - stall = 0; load_valid = 1 for a completed load only (not on timeout or store).
  - mem_en is ignored this cycle (it is the same instruction retiring); next state is IDLE.
- Flush:
  - In IDLE: suppresses the issue.
  - In WAIT: sets drop flag. The request cannot be retracted, so stall stays 1 until bus_ack or timeout.
  - With drop set, the FSM then goes to IDLE directly: no DONE cycle, no load_valid, no bus_err; load_data still updates.
- Minimum load latency: issue cycle + 1 WAIT cycle + DONE, so stall lasts 2 cycles with a same-cycle ack in the first WAIT cycle.
- load_data, byte_address and load_func hold their values until the next capture.
- bus_ack seen in IDLE or DONE is ignored.

Decomposition:
- mem_access_pkg holds:
  - func codes FUNC_B/BU/H/HU/W
  - FSM state encoding (2 bits)
  - BE constants (BE_WORD = 4'b1111, BE_HALF_LO, BE_HALF_HI)
- Sub-module store_align: purely combinational addr + func + wdata -> be, replicated wdata, addr_err. Shared with any future cache port.

Test Plan:
- LW addr 0x10000008, ack on the 2nd WAIT cycle with rdata 0xDEADBEEF -> bus_addr 0x10000008, be 1111, stall high 3 cycles; DONE cycle has load_valid = 1, load_data 0xDEADBEEF, byte_address 00, load_func 100.
- SB addr 0x10000003, wdata 0x000000A5, immediate ack -> bus_wr 1, be 1000, bus_wdata 0xA5A5A5A5, load_valid 0.
- LH addr 0x10000001, and LW addr 0x10000002 -> addr_err 1 in the same cycle, bus_req stays 0, stall 0; func 110 also gives addr_err 1.
- TIMEOUT = 4, no ack -> bus_req high exactly 4 cycles then 0, bus_err 1-cycle pulse, load_data 0, load_valid 0. Repeat with ack in the 4th cycle -> normal completion, no bus_err.
- LBU at 0x...02 with flush asserted in the 1st WAIT cycle, ack 2 cycles later -> stall held until ack, no load_valid; a new request is accepted in the next cycle.
- rst pulse in the middle of WAIT -> bus_req, stall and all outputs 0 asynchronously, before the next clk edge; a later bus_ack is ignored.

Source files
------------

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared func codes, byte-enable constants and FSM encoding for the MEM-stage access unit
package mem_access_pkg;

    localparam logic [2:0] FUNC_B  = 3'b000;
    localparam logic [2:0] FUNC_BU = 3'b001;
    localparam logic [2:0] FUNC_H  = 3'b010;
    localparam logic [2:0] FUNC_HU = 3'b011;
    localparam logic [2:0] FUNC_W  = 3'b100;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/store_align.sv
// rtl/store_align.sv - combinational byte-lane steering and alignment check for loads/stores
module store_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  func_choice,
    input  logic [1:0]  byte_offset,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misaligned
);

    always_comb begin
        be         = 4'b0000;
        wdata_rep  = wdata;
        misaligned = 1'b0;
        case (func_choice)
            FUNC_B, FUNC_BU: begin
                be        = BE_BYTE << byte_offset;
                wdata_rep = {4{wdata[7:0]}};
            end
            FUNC_H, FUNC_HU: begin
                be         = byte_offset[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = byte_offset[0];
            end
            FUNC_W: begin
                be         = BE_WORD;
                misaligned = |byte_offset;
            end
            // reserved func codes are reported as an address error
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data-memory access controller with req/ack bus handshake and timeout
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_wr,
    input  logic [2:0]  func_choice,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        stall,
    output logic        addr_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] load_data,
    output logic [1:0]  byte_address,
    output logic [2:0]  load_func,
    output logic        load_valid
);

    localparam bit             TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             drop;

    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic        misaligned;
    logic        issue;
    logic        timed_out;
    logic        drop_now;

    store_align u_store_align (
        .func_choice (func_choice),
        .byte_offset (addr[1:0]),
        .wdata       (wdata),
        .be          (be_c),
        .wdata_rep   (wdata_c),
        .misaligned  (misaligned)
    );

    assign addr_err  = mem_en & misaligned;
    assign issue     = (state == ST_IDLE) & mem_en & ~misaligned & ~flush;
    assign stall     = issue | (state == ST_WAIT);
    assign timed_out = TO_EN && (cnt == CNT_LAST);
    // a flush arriving together with the ack/timeout still drops the result
    assign drop_now  = drop | flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            drop         <= 1'b0;
            bus_req      <= 1'b0;
            bus_wr       <= 1'b0;
            bus_addr     <= '0;
            bus_be       <= '0;
            bus_wdata    <= '0;
            bus_err      <= 1'b0;
            load_data    <= '0;
            byte_address <= '0;
            load_func    <= '0;
            load_valid   <= 1'b0;
        end else begin
            bus_err    <= 1'b0;
            load_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        bus_req      <= 1'b1;
                        bus_wr       <= mem_wr;
                        bus_addr     <= {addr[31:2], 2'b00};
                        bus_be       <= be_c;
                        bus_wdata    <= wdata_c;
                        byte_address <= addr[1:0];
                        load_func    <= func_choice;
                        cnt          <= '0;
                        drop         <= 1'b0;
                        state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus_ack) begin
                        bus_req    <= 1'b0;
                        bus_wr     <= 1'b0;
                        if (!bus_wr) load_data <= bus_rdata;
                        load_valid <= ~bus_wr & ~drop_now;
                        drop       <= 1'b0;
                        state      <= drop_now ? ST_IDLE : ST_DONE;
                    end else if (timed_out) begin
                        bus_req <= 1'b0;
                        bus_wr  <= 1'b0;
                        if (!bus_wr) load_data <= '0;
                        bus_err <= ~drop_now;
                        drop    <= 1'b0;
                        state   <= drop_now ? ST_IDLE : ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (flush) drop <= 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
